seven_seg_display: RTL and testbench
====================================

SEVEN_SEG_DISPLAY -- requirements
Module: seven_seg_display

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of 7-segment digits (1..8).
REQ-002 SHALL have parameter WIDTH, default 8, input value width in bits (1..27).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 inverts every segment output bit.
REQ-004 SHALL have port clock  input  1  single system clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_value  input  WIDTH  unsigned value to display.
REQ-007 SHALL have port in_hex  input  1  1 = hexadecimal mode, 0 = decimal mode; sampled with in_value.
REQ-008 SHALL have port in_valid  input  1  request to load in_value and in_hex.
REQ-009 SHALL have port in_ready  output  1  block can accept a load this cycle.
REQ-010 SHALL have port seg_A_G  output  DIGITS*7  segment bus; digit k at bits [7k+6:7k], digit 0 least significant; within a digit A is the MSB, G the LSB.
REQ-011 SHALL have port overflow  output  1  displayed value did not fit in DIGITS digits.

Function
REQ-012 SHALL perform a load on any cycle where in_valid && in_ready; in_valid with in_ready low SHALL be ignored, not queued.
REQ-013 SHALL use FSM states IDLE, SHIFT, COMMIT; in_ready is high only in IDLE.
REQ-014 Hex load: IDLE->COMMIT; seg_A_G and overflow update on the edge ending COMMIT, i.e. 2 cycles after the accepting edge.
REQ-015 Decimal load: IDLE->SHIFT for exactly WIDTH cycles of shift-and-add-3 (double dabble), then COMMIT; outputs update WIDTH+2 cycles after the accepting edge.
REQ-016 COMMIT SHALL always return to IDLE; seg_A_G holds the previous value for the entire conversion.
REQ-017 Hex digit k SHALL show nibble k of in_value, zero-extended; decimal digit k SHALL show BCD digit k.
REQ-018 Overflow: if the value needs more than DIGITS digits in the selected radix, all digits SHALL show dash (G only) and overflow SHALL be 1; otherwise overflow 0.
REQ-019 Active-high codes (A..G): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47 dash=01 blank=00; inverted when ACTIVE_LOW=1.
REQ-020 BCD register SHALL be 4*ceil(WIDTH*0.302+1) bits so no intermediate value truncates.
REQ-021 Value 0 SHALL display digit 0 as "0" in both modes.

Reset
REQ-022 reset SHALL force state IDLE, in_ready 1, overflow 0, and every digit blank (00 active-high, 7F on bus when ACTIVE_LOW=1) on the next edge.
REQ-023 reset asserted mid-conversion SHALL abort it; the pending value SHALL never reach seg_A_G.
REQ-024 reset SHALL take priority over a simultaneous in_valid.

Configuration
REQ-025 Macro SEG_BLANK_LEADING_EN defined: leading zero digits above the most significant nonzero digit SHALL be blank; digit 0 always shown.
REQ-026 Macro SEG_BLANK_LEADING_EN undefined: all non-overflow digits SHALL show their value including leading zeros.

Verification
REQ-027 DIGITS=2, WIDTH=8, ACTIVE_LOW=0: load 42 decimal -> after 10 cycles seg_A_G = {33,6D}, overflow 0; in_ready low cycles 1..9, high cycle 10.
REQ-028 Same config: load 0xA7 hex -> after 2 cycles seg_A_G = {77,70}, overflow 0.
REQ-029 Same config: load 200 decimal -> seg_A_G = {01,01}, overflow 1; then load 0x00 hex -> {7E,7E} without SEG_BLANK_LEADING_EN, {00,7E} with it.
REQ-030 Load 99 decimal, assert reset at SHIFT cycle 4 -> all digits blank, in_ready 1 next cycle, 99 never displayed; in_valid pulses while in_ready low are dropped.
REQ-031 DIGITS=4, WIDTH=16, ACTIVE_LOW=1: load 9999 decimal -> seg_A_G digits each = ~7B (04) after 18 cycles; load 10000 -> all digits ~01 (7E), overflow 1.

Source files
------------

// File: rtl/seven_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_display
// Brief    : Loads an unsigned value and shows it on DIGITS seven-segment
//            digits in hex or decimal; decimal uses serial double dabble.
//            Optional macro SEG_BLANK_LEADING_EN blanks leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_display #(
    parameter int DIGITS     = 2,
    parameter int WIDTH      = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_value,
    input  logic                  in_hex,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DIGITS*7-1:0]   seg_A_G,
    output logic                  overflow
);

    localparam int c_BCD_DIGITS = (WIDTH * 302 + 1999) / 1000;
    localparam int c_BCD_W      = 4 * c_BCD_DIGITS;
    localparam int c_HEX_NIB    = (WIDTH + 3) / 4;
    localparam int c_MAX_A      = (DIGITS > c_HEX_NIB) ? DIGITS : c_HEX_NIB;
    localparam int c_MAX_NIB    = (c_MAX_A > c_BCD_DIGITS) ? c_MAX_A : c_BCD_DIGITS;
    // One spare nibble above the display keeps the overflow slice non-empty.
    localparam int c_PAD_W      = 4 * (c_MAX_NIB + 1);
    localparam int c_CNT_W      = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHIFT  = 2'd1;
    localparam logic [1:0] c_COMMIT = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [WIDTH-1:0]    r_bin;
    logic [c_BCD_W-1:0]  r_bcd;
    logic [c_BCD_W-1:0]  w_adj;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_hex;
    logic [DIGITS*7-1:0] r_seg;
    logic                r_overflow;
    logic [c_PAD_W-1:0]  w_nib_all;
    logic                w_ovf;
    logic [DIGITS*7-1:0] w_code;

    function automatic logic [6:0] f_seg(input logic [3:0] nib);
        case (nib)
            4'h0: f_seg = 7'h7E;
            4'h1: f_seg = 7'h30;
            4'h2: f_seg = 7'h6D;
            4'h3: f_seg = 7'h79;
            4'h4: f_seg = 7'h33;
            4'h5: f_seg = 7'h5B;
            4'h6: f_seg = 7'h5F;
            4'h7: f_seg = 7'h70;
            4'h8: f_seg = 7'h7F;
            4'h9: f_seg = 7'h7B;
            4'hA: f_seg = 7'h77;
            4'hB: f_seg = 7'h1F;
            4'hC: f_seg = 7'h4E;
            4'hD: f_seg = 7'h3D;
            4'hE: f_seg = 7'h4F;
            default: f_seg = 7'h47;
        endcase
    endfunction

    assign in_ready = (r_state == c_IDLE);
    assign seg_A_G  = (ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign overflow = r_overflow;

    always_ff @(posedge clock) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (in_valid) w_state_next = in_hex ? c_COMMIT : c_SHIFT;
            c_SHIFT:  if (r_cnt == '0) w_state_next = c_COMMIT;
            c_COMMIT: w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    // Add-3 correction applied before each shift of the double dabble.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < c_BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_hex      <= 1'b0;
            r_seg      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_bin <= in_value;
                        r_hex <= in_hex;
                        r_bcd <= '0;
                        r_cnt <= c_CNT_LOAD;
                    end
                end
                c_SHIFT: begin
                    r_bin <= r_bin << 1;
                    r_bcd <= {w_adj[c_BCD_W-2:0], r_bin[WIDTH-1]};
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                c_COMMIT: begin
                    r_seg      <= w_code;
                    r_overflow <= w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign w_nib_all = r_hex ? {{(c_PAD_W - WIDTH){1'b0}}, r_bin}
                             : {{(c_PAD_W - c_BCD_W){1'b0}}, r_bcd};
    assign w_ovf     = |(w_nib_all >> (4 * DIGITS));

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            logic [3:0] w_nib;
            assign w_nib = w_nib_all[4*k +: 4];
`ifdef SEG_BLANK_LEADING_EN
            logic w_lead_zero;
            assign w_lead_zero = (k != 0) && ((w_nib_all >> (4 * k)) == '0);
            assign w_code[7*k +: 7] = w_ovf       ? 7'h01 :
                                      w_lead_zero ? 7'h00 : f_seg(w_nib);
`else
            assign w_code[7*k +: 7] = w_ovf ? 7'h01 : f_seg(w_nib);
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_display
// Brief    : Directed self-checking bench for seven_seg_display (two configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_display;

    logic        clock;
    logic        reset;
    logic [7:0]  d1_value;
    logic        d1_hex, d1_valid, d1_ready, d1_ovf;
    logic [13:0] d1_seg;
    logic [15:0] d2_value;
    logic        d2_hex, d2_valid, d2_ready, d2_ovf;
    logic [27:0] d2_seg;

    int vectors = 0;
    int errors  = 0;

    seven_seg_display #(.DIGITS(2), .WIDTH(8), .ACTIVE_LOW(0)) u_dut1 (
        .clock(clock), .reset(reset), .in_value(d1_value), .in_hex(d1_hex),
        .in_valid(d1_valid), .in_ready(d1_ready), .seg_A_G(d1_seg), .overflow(d1_ovf)
    );

    seven_seg_display #(.DIGITS(4), .WIDTH(16), .ACTIVE_LOW(1)) u_dut2 (
        .clock(clock), .reset(reset), .in_value(d2_value), .in_hex(d2_hex),
        .in_valid(d2_valid), .in_ready(d2_ready), .seg_A_G(d2_seg), .overflow(d2_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic load1(input logic [7:0] v, input logic hex);
        d1_value = v;
        d1_hex   = hex;
        d1_valid = 1'b1;
        tick();
        d1_valid = 1'b0;
    endtask

    task automatic load2(input logic [15:0] v, input logic hex);
        d2_value = v;
        d2_hex   = hex;
        d2_valid = 1'b1;
        tick();
        d2_valid = 1'b0;
    endtask

    logic [13:0] exp_zero;
    logic [13:0] exp_seven;

    initial begin
`ifdef SEG_BLANK_LEADING_EN
        exp_zero  = {7'h00, 7'h7E};
        exp_seven = {7'h00, 7'h70};
`else
        exp_zero  = {7'h7E, 7'h7E};
        exp_seven = {7'h7E, 7'h70};
`endif
        reset = 1'b1;
        d1_value = '0; d1_hex = 1'b0; d1_valid = 1'b0;
        d2_value = '0; d2_hex = 1'b0; d2_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_d1_seg",   32'(d1_seg),   32'h0);
        check("rst_d1_ovf",   32'(d1_ovf),   32'h0);
        check("rst_d1_ready", 32'(d1_ready), 32'h1);
        check("rst_d2_seg",   32'(d2_seg),   32'h0FFF_FFFF);
        check("rst_d2_ready", 32'(d2_ready), 32'h1);

        // Decimal 42: busy for cycles 1..9, result visible in cycle 10.
        load1(8'd42, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            check("dec42_busy", 32'(d1_ready), 32'h0);
            check("dec42_hold", 32'(d1_seg),   32'h0);
            tick();
        end
        check("dec42_seg",   32'(d1_seg),   32'({7'h33, 7'h6D}));
        check("dec42_ovf",   32'(d1_ovf),   32'h0);
        check("dec42_ready", 32'(d1_ready), 32'h1);

        load1(8'hA7, 1'b1);
        check("hexA7_busy", 32'(d1_ready), 32'h0);
        check("hexA7_hold", 32'(d1_seg),   32'({7'h33, 7'h6D}));
        tick();
        check("hexA7_seg", 32'(d1_seg), 32'({7'h77, 7'h70}));
        check("hexA7_ovf", 32'(d1_ovf), 32'h0);

        load1(8'd200, 1'b0);
        repeat (9) tick();
        check("dec200_seg", 32'(d1_seg), 32'({7'h01, 7'h01}));
        check("dec200_ovf", 32'(d1_ovf), 32'h1);

        load1(8'h00, 1'b1);
        tick();
        check("hex00_seg", 32'(d1_seg), 32'(exp_zero));
        check("hex00_ovf", 32'(d1_ovf), 32'h0);

        load1(8'd7, 1'b0);
        repeat (9) tick();
        check("dec7_seg", 32'(d1_seg), 32'(exp_seven));

        // Decimal 99 aborted by reset in SHIFT cycle 4; a pulse at cycle 2 is dropped.
        load1(8'd99, 1'b0);
        check("abort_hold", 32'(d1_seg), 32'(exp_seven));
        tick();
        d1_value = 8'h11; d1_hex = 1'b1; d1_valid = 1'b1;
        tick();
        d1_valid = 1'b0;
        check("abort_busy", 32'(d1_ready), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_seg",   32'(d1_seg),   32'h0);
        check("abort_ready", 32'(d1_ready), 32'h1);
        check("abort_ovf",   32'(d1_ovf),   32'h0);
        repeat (12) begin
            tick();
            check("abort_no99", 32'(d1_seg), 32'h0);
        end

        // Reset wins over a simultaneous load request.
        reset = 1'b1; d1_value = 8'h55; d1_hex = 1'b1; d1_valid = 1'b1;
        tick();
        reset = 1'b0; d1_valid = 1'b0;
        check("rstprio_ready", 32'(d1_ready), 32'h1);
        tick();
        tick();
        check("rstprio_seg", 32'(d1_seg), 32'h0);

        load1(8'd99, 1'b0);
        repeat (9) tick();
        check("dec99_seg", 32'(d1_seg), 32'({7'h7B, 7'h7B}));
        check("dec99_ovf", 32'(d1_ovf), 32'h0);

        // Four-digit, active-low instance.
        load2(16'd9999, 1'b0);
        repeat (16) tick();
        check("d2_9999_busy", 32'(d2_ready), 32'h0);
        tick();
        check("d2_9999_seg",   32'(d2_seg),   32'({4{7'h04}}));
        check("d2_9999_ovf",   32'(d2_ovf),   32'h0);
        check("d2_9999_ready", 32'(d2_ready), 32'h1);

        load2(16'd10000, 1'b0);
        repeat (17) tick();
        check("d2_10000_seg", 32'(d2_seg), 32'({4{7'h7E}}));
        check("d2_10000_ovf", 32'(d2_ovf), 32'h1);

        load2(16'hBEEF, 1'b1);
        tick();
        check("d2_beef_seg", 32'(d2_seg), 32'({7'h60, 7'h30, 7'h30, 7'h38}));
        check("d2_beef_ovf", 32'(d2_ovf), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
